// File: rtl/ysyx_22040750_trap_ctrl.sv
// ysyx_22040750_trap_ctrl: ecall/mret/timer-irq trap sequencer; TRAP_VECTORED_EN enables vectored interrupt targets
module ysyx_22040750_trap_ctrl #(
  parameter logic [63:0] ECALL_CAUSE = 64'd11,
  parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_wb_valid,
  input  logic        I_wb_ecall,
  input  logic        I_wb_mret,
  input  logic [31:0] I_wb_pc,
  input  logic [31:0] I_irq_pc,
  input  logic        I_timer_irq,
  input  logic        I_mstatus_mie,
  input  logic        I_mie_mtie,
  input  logic [63:0] I_csr_rd_data,
  output logic        O_csr_intr_wr,
  output logic        O_csr_intr_rd,
  output logic        O_csr_mret_wr,
  output logic        O_csr_mret_rd,
  output logic [31:0] O_intr_pc,
  output logic [63:0] O_csr_intr_no,
  output logic        O_flush,
  output logic        O_busy,
  output logic        O_redirect_valid,
  output logic [31:0] O_redirect_pc,
  input  logic        I_redirect_ready
);
  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
  state_t state;
  logic is_irq;
  logic ecall_ev, mret_ev, irq_ev, trap_ev;
  logic [31:0] base, vec_tgt, target;
  assign ecall_ev = I_wb_valid & I_wb_ecall;
  assign mret_ev  = I_wb_valid & I_wb_mret & ~I_wb_ecall;
  assign irq_ev   = I_timer_irq & I_mstatus_mie & I_mie_mtie & I_wb_valid & ~I_wb_ecall & ~I_wb_mret;
  assign trap_ev  = ecall_ev | irq_ev;
  assign base     = {I_csr_rd_data[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign vec_tgt  = (is_irq && I_csr_rd_data[1:0] == 2'b01) ? base + {24'd0, O_csr_intr_no[5:0], 2'b00} : base;
  logic unused_ok;
  assign unused_ok = &{1'b0, I_csr_rd_data[63:32]};
`else
  assign vec_tgt  = base;
  logic unused_ok;
  assign unused_ok = &{1'b0, I_csr_rd_data[63:32], is_irq};
`endif
  assign target   = O_csr_mret_wr ? I_csr_rd_data[31:0] : vec_tgt;
  // Sequencer: capture event in IDLE, strobe CSRs in COMMIT, hold redirect until IF accepts
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state            <= IDLE;
      is_irq           <= 1'b0;
      O_csr_intr_wr    <= 1'b0;
      O_csr_intr_rd    <= 1'b0;
      O_csr_mret_wr    <= 1'b0;
      O_csr_mret_rd    <= 1'b0;
      O_intr_pc        <= 32'd0;
      O_csr_intr_no    <= 64'd0;
      O_flush          <= 1'b0;
      O_busy           <= 1'b0;
      O_redirect_valid <= 1'b0;
      O_redirect_pc    <= 32'd0;
    end else begin
      case (state)
        IDLE: if (trap_ev | mret_ev) begin
          state         <= COMMIT;
          is_irq        <= irq_ev;
          O_csr_intr_wr <= trap_ev;
          O_csr_intr_rd <= trap_ev;
          O_csr_mret_wr <= mret_ev;
          O_csr_mret_rd <= mret_ev;
          O_intr_pc     <= ecall_ev ? I_wb_pc : irq_ev ? I_irq_pc : 32'd0;
          O_csr_intr_no <= ecall_ev ? ECALL_CAUSE : irq_ev ? TIMER_CAUSE : 64'd0;
          O_flush       <= 1'b1;
          O_busy        <= 1'b1;
        end
        COMMIT: begin
          state            <= REDIRECT;
          O_csr_intr_wr    <= 1'b0;
          O_csr_intr_rd    <= 1'b0;
          O_csr_mret_wr    <= 1'b0;
          O_csr_mret_rd    <= 1'b0;
          O_intr_pc        <= 32'd0;
          O_csr_intr_no    <= 64'd0;
          O_redirect_valid <= 1'b1;
          O_redirect_pc    <= target;
        end
        default: if (I_redirect_ready) begin
          state            <= IDLE;
          is_irq           <= 1'b0;
          O_flush          <= 1'b0;
          O_busy           <= 1'b0;
          O_redirect_valid <= 1'b0;
          O_redirect_pc    <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// tb_ysyx_22040750_trap_ctrl: table-driven and directed checks of the trap sequencer
module tb_ysyx_22040750_trap_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wb_valid = 0, wb_ecall = 0, wb_mret = 0, timer_irq = 0, mie = 0, mtie = 0, ready = 0;
  logic [31:0] wb_pc = 0, irq_pc = 0;
  logic [63:0] csr_rd = 0;
  logic        intr_wr, intr_rd, mret_wr, mret_rd, flush, busy, rvalid;
  logic [31:0] intr_pc, rpc;
  logic [63:0] intr_no;
  int          tests = 0, fails = 0;
  localparam logic [63:0] EC = 64'd11, TM = 64'h8000_0000_0000_0007;
  always #5 clk = ~clk;
  ysyx_22040750_trap_ctrl dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_wb_valid(wb_valid), .I_wb_ecall(wb_ecall), .I_wb_mret(wb_mret),
    .I_wb_pc(wb_pc), .I_irq_pc(irq_pc), .I_timer_irq(timer_irq), .I_mstatus_mie(mie), .I_mie_mtie(mtie),
    .I_csr_rd_data(csr_rd), .O_csr_intr_wr(intr_wr), .O_csr_intr_rd(intr_rd), .O_csr_mret_wr(mret_wr),
    .O_csr_mret_rd(mret_rd), .O_intr_pc(intr_pc), .O_csr_intr_no(intr_no), .O_flush(flush), .O_busy(busy),
    .O_redirect_valid(rvalid), .O_redirect_pc(rpc), .I_redirect_ready(ready)
  );
  typedef struct {
    logic ec, mr, irq, ie, te;
    logic [31:0] wpc, ipc, csr;
    logic take, km;
    logic [31:0] epc;
    logic [63:0] eno;
    logic [31:0] tgt;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic clear_in();
    wb_valid = 0; wb_ecall = 0; wb_mret = 0; timer_irq = 0; mie = 0; mtie = 0;
  endtask
  task automatic run_vec(input vec_t x, input int i);
    @(negedge clk);
    wb_valid = 1; wb_ecall = x.ec; wb_mret = x.mr; timer_irq = x.irq; mie = x.ie; mtie = x.te;
    wb_pc = x.wpc; irq_pc = x.ipc; csr_rd = {32'd0, x.csr}; ready = 1;
    @(negedge clk);
    clear_in();
    if (!x.take) begin
      chk($sformatf("v%0d busy_idle", i), busy, 0);
      chk($sformatf("v%0d nowr", i), intr_wr | mret_wr, 0);
    end else begin
      chk($sformatf("v%0d busy", i), busy, 1);
      chk($sformatf("v%0d flush", i), flush, 1);
      chk($sformatf("v%0d intr_wr", i), intr_wr, !x.km);
      chk($sformatf("v%0d intr_rd", i), intr_rd, !x.km);
      chk($sformatf("v%0d mret_wr", i), mret_wr, x.km);
      chk($sformatf("v%0d mret_rd", i), mret_rd, x.km);
      chk($sformatf("v%0d intr_pc", i), intr_pc, x.epc);
      chk($sformatf("v%0d intr_no", i), intr_no, x.eno);
      @(negedge clk);
      chk($sformatf("v%0d rvalid", i), rvalid, 1);
      chk($sformatf("v%0d rpc", i), rpc, x.tgt);
      chk($sformatf("v%0d strobe_off", i), {intr_wr, mret_wr, intr_rd, mret_rd}, 0);
      chk($sformatf("v%0d no_off", i), intr_no, 0);
      chk($sformatf("v%0d pc_off", i), intr_pc, 0);
      @(negedge clk);
      chk($sformatf("v%0d done", i), {busy, rvalid, flush}, 0);
    end
  endtask
  initial begin
    //        ec mr irq ie te  wpc           ipc           csr           take km epc           eno tgt
    v[0]  = '{1, 0, 0, 0, 0, 32'h8000_0040, 32'h8000_0200, 32'h8000_0100, 1, 0, 32'h8000_0040, EC, 32'h8000_0100};
    v[1]  = '{0, 1, 0, 0, 0, 32'h8000_0040, 32'h8000_0200, 32'h8000_0044, 1, 1, 32'h0,         0,  32'h8000_0044};
    v[2]  = '{0, 0, 1, 1, 1, 32'h8000_0040, 32'h8000_0200, 32'h8000_0100, 1, 0, 32'h8000_0200, TM, 32'h8000_0100};
    v[3]  = '{0, 0, 1, 0, 1, 32'h8000_0040, 32'h8000_0200, 32'h8000_0100, 0, 0, 32'h0,         0,  32'h0};
    v[4]  = '{0, 0, 1, 1, 0, 32'h8000_0040, 32'h8000_0200, 32'h8000_0100, 0, 0, 32'h0,         0,  32'h0};
    v[5]  = '{1, 0, 1, 1, 1, 32'h8000_0040, 32'h8000_0200, 32'h8000_0100, 1, 0, 32'h8000_0040, EC, 32'h8000_0100};
    v[6]  = '{1, 1, 0, 0, 0, 32'h8000_0048, 32'h8000_0200, 32'h8000_0100, 1, 0, 32'h8000_0048, EC, 32'h8000_0100};
    v[7]  = '{0, 1, 1, 1, 1, 32'h8000_0040, 32'h8000_0200, 32'h8000_0044, 1, 1, 32'h0,         0,  32'h8000_0044};
`ifdef TRAP_VECTORED_EN
    v[8]  = '{0, 0, 1, 1, 1, 32'h8000_0040, 32'h8000_0300, 32'h8000_1001, 1, 0, 32'h8000_0300, TM, 32'h8000_101C};
`else
    v[8]  = '{0, 0, 1, 1, 1, 32'h8000_0040, 32'h8000_0300, 32'h8000_1001, 1, 0, 32'h8000_0300, TM, 32'h8000_1000};
`endif
    v[9]  = '{1, 0, 0, 0, 0, 32'h8000_0050, 32'h8000_0200, 32'h8000_1001, 1, 0, 32'h8000_0050, EC, 32'h8000_1000};
    v[10] = '{1, 0, 0, 0, 0, 32'h8000_0054, 32'h8000_0200, 32'h8000_0103, 1, 0, 32'h8000_0054, EC, 32'h8000_0100};
    v[11] = '{0, 1, 0, 0, 0, 32'h8000_0040, 32'h8000_0200, 32'h8000_0046, 1, 1, 32'h0,         0,  32'h8000_0046};
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {intr_wr, intr_rd, mret_wr, mret_rd, flush, rvalid}, 0);
    chk("rst_data", {intr_pc, rpc}, 0);
    chk("rst_no", intr_no, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) run_vec(v[i], i);
    // mret with ready held low: redirect must stay stable
    @(negedge clk);
    ready = 0; wb_valid = 1; wb_mret = 1; csr_rd = 64'h8000_0044;
    @(negedge clk);
    clear_in();
    chk("hold_mret_wr", mret_wr, 1);
    @(negedge clk);
    chk("hold_mret_pulse", mret_wr, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_valid%0d", k), rvalid, 1);
      chk($sformatf("hold_pc%0d", k), rpc, 32'h8000_0044);
      chk($sformatf("hold_busy%0d", k), busy, 1);
      @(negedge clk);
    end
    ready = 1;
    @(negedge clk);
    chk("hold_release", {busy, rvalid}, 0);
    // ecall beats irq; still-pending irq retaken from IDLE
    wb_valid = 1; wb_ecall = 1; timer_irq = 1; mie = 1; mtie = 1; wb_pc = 32'h8000_0060; irq_pc = 32'h8000_0064;
    csr_rd = 64'h8000_0100;
    @(negedge clk);
    wb_ecall = 0;
    chk("pri_no", intr_no, EC);
    chk("pri_pc", intr_pc, 32'h8000_0060);
    @(negedge clk);
    chk("pri_redir", rvalid, 1);
    @(negedge clk);
    chk("pri_idle", busy, 0);
    @(negedge clk);
    clear_in();
    chk("retake_no", intr_no, TM);
    chk("retake_pc", intr_pc, 32'h8000_0064);
    @(negedge clk);
    @(negedge clk);
    chk("retake_done", busy, 0);
    // reset during REDIRECT aborts asynchronously
    ready = 0; wb_valid = 1; wb_ecall = 1; wb_pc = 32'h8000_0040;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    chk("rr_in_redirect", rvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("rr_outs", {intr_wr, intr_rd, mret_wr, mret_rd, flush, rvalid, busy}, 0);
    chk("rr_data", {intr_pc, rpc}, 0);
    chk("rr_no", intr_no, 0);
    @(negedge clk);
    rst_n = 1;
    run_vec(v[0], 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
